shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 165 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle barrel shifter. An operation is accepted in IDLE, then
// processed one binary stage per clock (shift/rotate by 1, 2, 4 and 8 bits
// as selected by amt). The result is presented in DONE until the consumer
// takes it. Latency is fixed at four SHIFT cycles whatever amt is.
//
// Ports
//   clk        single clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   requester presents an operation
//   in_ready   sequencer can accept (high only in IDLE)
//   data       operand, WIDTH bits
//   amt        shift amount in bits, AMT_W bits (0..WIDTH-1)
//   dir        0 = left, 1 = right
//   rot        0 = logical (zero fill), 1 = rotate
//   out_valid  q holds a valid result (high only in DONE)
//   out_ready  consumer accepts the result
//   q          registered result
//   busy       high in SHIFT or DONE (complement of in_ready)
//
// Only WIDTH = 16 with AMT_W = 4 is supported.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic             rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One stage per bit of amt, so the stage counter needs log2(AMT_W) bits.
    localparam int STAGE_W = 2;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(AMT_W - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q,  work_d;
    logic [WIDTH-1:0]     q_q,     q_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [AMT_W-1:0]     amt_q,   amt_d;
    logic                 dir_q,   dir_d;
    logic                 rot_q,   rot_d;

    // Result of applying each stage's fixed shift (2^k) to the current work
    // value. The constant shift distances let each candidate be plain wiring;
    // the FSM then picks the one belonging to the current stage.
    logic [WIDTH-1:0]     stage_res [AMT_W];
    logic [WIDTH-1:0]     stage_out;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [WIDTH-1:0] left_v;
        logic [WIDTH-1:0] right_v;

        // Vacated positions take either zeros or the bits pushed out at the
        // far end, depending on rot.
        always_comb begin
            left_v  = {work_q[WIDTH-1-S:0],
                       rot_q ? work_q[WIDTH-1:WIDTH-S] : {S{1'b0}}};
            right_v = {rot_q ? work_q[S-1:0] : {S{1'b0}},
                       work_q[WIDTH-1:S]};
        end

        assign stage_res[k] = dir_q ? right_v : left_v;
    end

    // A stage whose amt bit is clear still burns its clock but holds work,
    // which is what keeps the latency independent of amt.
    always_comb begin
        stage_out = work_q;
        if (amt_q[stage_q]) begin
            stage_out = stage_res[stage_q];
        end
    end

    // Next-state and datapath update. Captured fields only change on the
    // accept edge; q only changes on the edge that finishes the last stage,
    // so it stays put throughout DONE and afterwards.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        q_d     = q_q;
        stage_d = stage_q;
        amt_d   = amt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = data;
                    amt_d   = amt;
                    dir_d   = dir;
                    rot_d   = rot;
                    stage_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = stage_out;
                if (stage_q == LAST_STAGE) begin
                    // Counter parks on the last stage instead of wrapping.
                    q_d     = stage_out;
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight and clears all
    // datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            q_q     <= '0;
            stage_q <= '0;
            amt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            q_q     <= q_d;
            stage_q <= stage_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
        end
    end

    // Handshake outputs are decoded from the state register only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state_q == DONE);
    assign q         = q_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed self-checking bench for shift_sequencer. Expected results are
// hand-computed constants. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data;
    logic [3:0]  amt;
    logic        dir;
    logic        rot;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        busy;

    int checks;
    int errors;

    shift_sequencer #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .amt       (amt),
        .dir       (dir),
        .rot       (rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .busy      (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge, then scramble the inputs so any late
    // sampling would corrupt the result. Returns the edges from accept until
    // out_valid rose (bounded).
    task automatic startAndWait(input logic [15:0] d, input logic [3:0] a,
                                input logic dr, input logic rt,
                                output int edges);
        in_valid = 1'b1;
        data     = d;
        amt      = a;
        dir      = dr;
        rot      = rt;
        stepEdge();
        in_valid = 1'b0;
        data     = ~d;
        amt      = ~a;
        dir      = ~dr;
        rot      = ~rt;
        edges    = 0;
        while (!out_valid && edges < 20) begin
            stepEdge();
            edges++;
        end
    endtask

    // Full operation: accept, check latency and result, then drain.
    task automatic applyStimulus(input string tag, input logic [15:0] d,
                                 input logic [3:0] a, input logic dr,
                                 input logic rt, input logic [15:0] exp_q);
        int edges;
        startAndWait(d, a, dr, rt, edges);
        checkOutput({tag, " latency"}, 16'(edges), 16'd4);
        checkOutput({tag, " q"}, q, exp_q);
        out_ready = 1'b1;
        stepEdge();
        out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, " in_ready back"}, {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        int edges;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        data      = 16'h1234;
        amt       = 4'd3;
        dir       = 1'b0;
        rot       = 1'b0;

        // Reset state, with in_valid asserted and ignored.
        stepEdge();
        stepEdge();
        checkOutput("reset in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("reset q", q, 16'h0000);
        in_valid = 1'b0;
        rst      = 1'b0;
        stepEdge();

        // Directed vectors.
        applyStimulus("lsl4", 16'h0001, 4'd4, 1'b0, 1'b0, 16'h0010);
        applyStimulus("ror1", 16'h8001, 4'd1, 1'b1, 1'b1, 16'hC000);
        applyStimulus("lsr1", 16'h8001, 4'd1, 1'b1, 1'b0, 16'h4000);
        applyStimulus("lsl15", 16'hFFFF, 4'd15, 1'b0, 1'b0, 16'h8000);
        applyStimulus("rol15", 16'hFFFF, 4'd15, 1'b0, 1'b1, 16'hFFFF);
        applyStimulus("amt0", 16'hA5C3, 4'd0, 1'b0, 1'b0, 16'hA5C3);
        applyStimulus("ror4", 16'h1234, 4'd4, 1'b1, 1'b1, 16'h4123);
        applyStimulus("rol8", 16'h1234, 4'd8, 1'b0, 1'b1, 16'h3412);
        applyStimulus("lsr7", 16'hF000, 4'd7, 1'b1, 1'b0, 16'h01E0);

        // Backpressure: hold out_ready low in DONE while wiggling the inputs.
        startAndWait(16'h00F0, 4'd4, 1'b1, 1'b0, edges);
        checkOutput("bp latency", 16'(edges), 16'd4);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            data     = 16'(i * 16'h1111 + 16'h0101);
            amt      = 4'(i);
            stepEdge();
            checkOutput("bp q stable", q, 16'h000F);
            checkOutput("bp out_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("bp in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepEdge();
        out_ready = 1'b0;
        checkOutput("bp release out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("bp release in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("bp q retained", q, 16'h000F);

        // Reset during SHIFT stage 2 aborts the operation at once.
        in_valid = 1'b1;
        data     = 16'h0F0F;
        amt      = 4'd5;
        dir      = 1'b0;
        rot      = 1'b1;
        stepEdge();
        in_valid = 1'b0;
        stepEdge();
        stepEdge();
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("abort busy", {15'd0, busy}, 16'd0);
        checkOutput("abort in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("abort q cleared", q, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort still idle", {15'd0, in_ready}, 16'd1);
        applyStimulus("post-abort", 16'h0003, 4'd2, 1'b0, 1'b0, 16'h000C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
